spi_mem_arbiter: RTL
====================

# spi_mem_arbiter

Single-port buffer arbiter in the SysClk domain. It shares one byte-wide buffer RAM port between two requesters:
- the SPI engine's memory port, after it has been retimed to SysClk;
- the processor bus-side port.

The SPI engine gets fixed priority, bounded by a starvation counter so the CPU always makes progress. The block routes 1-cycle-latency read data back to whichever requester issued the read.

## Interface
Parameters:
- AddrBits, 12, buffer address width
- StarveLimit, 4, consecutive lost-contention cycles after which the CPU wins; legal range 1..15

Ports:
- SysClk  in  1  system clock; all logic on posedge
- Reset_n  in  1  synchronous, active-low reset
- spiReq  in  1  SPI requester access request; addr/data/WE held stable until granted
- spiWE  in  1  1 = write, 0 = read
- spiAddr  in  AddrBits  SPI access address
- spiWData  in  8  SPI write data
- spiGrant  out  1  access performed this cycle
- spiRData  out  8  read data; valid only when spiRValid
- spiRValid  out  1  one-cycle pulse, the cycle after a granted SPI read
- cpuReq, cpuWE, cpuAddr, cpuWData  in  1/1/AddrBits/8  CPU requester, same rules as SPI
- cpuGrant, cpuRData, cpuRValid  out  1/8/1  CPU counterparts
- memAddr  out  AddrBits  RAM address
- memWData  out  8  RAM write data
- memWE  out  1  RAM write enable
- memRData  in  8  RAM read data, valid one cycle after address

## Operation
- Grants are combinational from the requests and the registered starve counter.
  - At most one grant is asserted per cycle.
  - Neither grant asserts while Reset_n = 0.
- Arbitration each cycle:
  - Only spiReq asserted: SPI granted.
  - Only cpuReq asserted: CPU granted.
  - Both asserted: CPU granted if starveCnt == StarveLimit, otherwise SPI granted.
  - Neither asserted: no grant, memWE = 0.
- The memory port is muxed from the granted requester.
  - memWE = granted requester's WE, and 0 when nothing is granted.
  - With no grant, memAddr/memWData hold the SPI inputs (don't-care).
- starveCnt (4 bits, registered):
  - Increments, saturating at StarveLimit, when cpuReq=1 and cpuGrant=0.
  - Clears to 0 when cpuGrant=1 or cpuReq=0.
- Read return uses a registered owner pair {rdSpi, rdCpu}.
  - Set on a granted read (WE=0); cleared otherwise.
  - spiRValid = rdSpi and cpuRValid = rdCpu.
  - Both RData outputs = memRData, unregistered.
- Writes complete at the grant edge and produce no RValid.
- Requesters may issue back-to-back accesses; each granted read yields exactly one RValid, in order.

## Timing
- Cycle N: req with grant means the RAM is addressed in cycle N.
  - A write commits at the end of N.
  - Read data and the RValid pulse appear in cycle N+1.
- Grant latency:
  - SPI, uncontended: 0 cycles.
  - CPU, contended: at most StarveLimit+1 cycles after cpuReq rises, assuming SPI requests every cycle.
- After a forced CPU win, starveCnt = 0, so SPI wins the next contended cycle.
- Reset values: spiGrant=0, cpuGrant=0, spiRValid=0, cpuRValid=0, memWE=0, starveCnt=0, rdSpi=rdCpu=0.
- Reset mid-operation:
  - A read granted in the cycle Reset_n falls produces no RValid.
  - A pending, ungranted request is not remembered; it is re-arbitrated after reset.
- Simultaneous events:
  - If cpuReq drops in the same cycle starveCnt would saturate, the counter clears.
  - Requests that change before grant are a requester protocol violation; the arbiter does not check for them.

## Test plan
- Reset: hold Reset_n=0 with both reqs asserted for 3 cycles -> both grants 0, memWE=0, both RValid 0; release -> SPI granted in the first cycle.
- SPI write then read: spiWE=1, addr 0x005, data 0xA5, then read 0x005 -> spiGrant both cycles, spiRValid=1 with spiRData=0xA5 the cycle after the read grant, cpuRValid stays 0.
- Starvation: StarveLimit=4, spiReq held 1 continuously, cpuReq read of addr 0x010 held -> SPI granted 4 cycles, CPU granted on the 5th, then SPI resumes; cpuRValid the following cycle.
- Interleaved reads: CPU read 0x001 (holds 0x11) granted in cycle N, SPI read 0x002 (holds 0x22) granted in N+1 -> cpuRValid/0x11 in N+1, spiRValid/0x22 in N+2, never both high in one cycle.
- Counter clear: CPU waits 3 cycles, then drops cpuReq for one cycle, then reasserts -> starveCnt restarts at 0 and the CPU needs a full 4 more losses before winning.
- Reset during read: CPU read granted in cycle N with Reset_n=0 in N -> cpuRValid stays 0 in N+1.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// Shares one byte-wide buffer RAM port between the SPI engine and the CPU.
// SPI has fixed priority; a starvation counter guarantees the CPU a win after StarveLimit losses.
module spi_mem_arbiter #(
  parameter int AddrBits    = 12,
  parameter int StarveLimit = 4
) (
  input  logic                SysClk,
  input  logic                Reset_n,

  input  logic                spiReq,
  input  logic                spiWE,
  input  logic [AddrBits-1:0] spiAddr,
  input  logic [7:0]          spiWData,
  output logic                spiGrant,
  output logic [7:0]          spiRData,
  output logic                spiRValid,

  input  logic                cpuReq,
  input  logic                cpuWE,
  input  logic [AddrBits-1:0] cpuAddr,
  input  logic [7:0]          cpuWData,
  output logic                cpuGrant,
  output logic [7:0]          cpuRData,
  output logic                cpuRValid,

  output logic [AddrBits-1:0] memAddr,
  output logic [7:0]          memWData,
  output logic                memWE,
  input  logic [7:0]          memRData
);

  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  logic [3:0] starve_q, starve_d;
  logic       rd_spi_q, rd_spi_d;
  logic       rd_cpu_q, rd_cpu_d;
  logic       cpu_win, spi_win;

  // CPU wins when alone, or when it has lost contention StarveLimit times in a row
  always_comb begin
    cpu_win = cpuReq & (~spiReq | (starve_q == StarveMax));
    spi_win = spiReq & ~cpu_win;
  end

  assign spiGrant = Reset_n & spi_win;
  assign cpuGrant = Reset_n & cpu_win;

  // With no grant the port idles on the SPI inputs; memWE is the only qualifier
  assign memAddr  = cpuGrant ? cpuAddr  : spiAddr;
  assign memWData = cpuGrant ? cpuWData : spiWData;
  assign memWE    = (spiGrant & spiWE) | (cpuGrant & cpuWE);

  always_comb begin
    starve_d = 4'd0;
    if (cpuReq && !cpuGrant) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
    end
    rd_spi_d = spiGrant & ~spiWE;
    rd_cpu_d = cpuGrant & ~cpuWE;
  end

  always_ff @(posedge SysClk) begin
    if (!Reset_n) begin
      starve_q <= 4'd0;
      rd_spi_q <= 1'b0;
      rd_cpu_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rd_spi_q <= rd_spi_d;
      rd_cpu_q <= rd_cpu_d;
    end
  end

  // RAM data arrives one cycle after the address; the owner flags steer it back
  assign spiRValid = rd_spi_q;
  assign cpuRValid = rd_cpu_q;
  assign spiRData  = memRData;
  assign cpuRData  = memRData;

endmodule
